// File: rtl/turbo_rx_pkg.sv
// Shared constants, FSM encoding and the PB length legality check for the
// turbo_rx feeder path.
package turbo_rx_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 2;

  localparam logic [ADDR_W-1:0] LEN_PB16  = 12'h040;
  localparam logic [ADDR_W-1:0] LEN_PB136 = 12'h220;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_KICK = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  // Only the two PHY block sizes turbo_rx understands are accepted.
  function automatic logic is_legal_len(input logic [ADDR_W-1:0] len);
    return (len == LEN_PB16) || (len == LEN_PB136);
  endfunction

endpackage

// File: rtl/turbo_rx_pb_loader_if.sv
// Bundle of the soft-pair input stream, the PB configuration and the
// write/read-phase controls presented to turbo_rx.
interface turbo_rx_pb_loader_if;
  import turbo_rx_pkg::*;

  logic [DATA_W-1:0] s_data;
  logic              s_vld;
  logic              s_sop;
  logic              s_rdy;
  logic [ADDR_W-1:0] cfg_pb_len;
  logic [ADDR_W-1:0] cfg_pb_offset;
  logic              cfg_mode;

  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] waddr;
  logic              wen;
  logic [ADDR_W-1:0] pb_offset;
  logic [ADDR_W-1:0] pb_len;
  logic              mod_int_dint;
  logic              start;
  logic              din_vld;
  logic              busy;
  logic              err_len;

  // Upstream source / observer side.
  modport master (
    output s_data, s_vld, s_sop, cfg_pb_len, cfg_pb_offset, cfg_mode,
    input  s_rdy, wdata, waddr, wen, pb_offset, pb_len, mod_int_dint,
           start, din_vld, busy, err_len
  );

  // Loader side.
  modport slave (
    input  s_data, s_vld, s_sop, cfg_pb_len, cfg_pb_offset, cfg_mode,
    output s_rdy, wdata, waddr, wen, pb_offset, pb_len, mod_int_dint,
           start, din_vld, busy, err_len
  );
endinterface

// File: rtl/turbo_rx_addr_gen.sv
// Write-port stage: forms base + index (wrapping at the address width) and
// registers the memory write strobe, address and data.
module turbo_rx_addr_gen
  import turbo_rx_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  logic              wen_q,   wen_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Next write: strobe follows the request; address/data only move on a write.
  always_comb begin
    wen_d   = wr_req;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (wr_req) begin
      // The sum is truncated to ADDR_W bits, which gives the silent FFF->000 wrap.
      waddr_d = wr_base + wr_idx;
      wdata_d = wr_data;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: the data/address registers are reset too (not just the strobe),
      // so every output is a defined 0 straight out of reset.
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state, so each flop samples
      // the pre-edge value of every other flop.
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: rtl/turbo_rx_pb_loader.sv
// Loads one PHY block of soft pairs into turbo_rx's interleaver memory, then
// kicks the read phase and holds din_vld for pb_len/4 cycles.
module turbo_rx_pb_loader
  import turbo_rx_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_rst,
  turbo_rx_pb_loader_if.slave  bus
);

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] idx_q,       idx_d;
  logic [ADDR_W-1:0] run_cnt_q,   run_cnt_d;
  logic [ADDR_W-1:0] pb_len_q,    pb_len_d;
  logic [ADDR_W-1:0] pb_offset_q, pb_offset_d;
  logic              mode_q,      mode_d;
  logic              s_rdy_q,     s_rdy_d;
  logic              start_q,     start_d;
  logic              din_vld_q,   din_vld_d;
  logic              busy_q,      busy_d;
  logic              err_len_q,   err_len_d;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_base;
  logic [ADDR_W-1:0] wr_idx;

  logic accept;
  logic sop_acc;

  assign accept  = bus.s_vld & s_rdy_q;
  assign sop_acc = accept & bus.s_sop;

  // FSM next-state, counters, latched configuration and write requests.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    run_cnt_d   = run_cnt_q;
    pb_len_d    = pb_len_q;
    pb_offset_d = pb_offset_q;
    mode_d      = mode_q;
    start_d     = 1'b0;
    din_vld_d   = 1'b0;
    err_len_d   = 1'b0;
    wr_req      = 1'b0;
    wr_base     = pb_offset_q;
    wr_idx      = idx_q;

    case (state_q)
      // A start-of-PB behaves identically in IDLE and LOAD; in LOAD it
      // silently abandons the partially written block.
      ST_IDLE, ST_LOAD: begin
        if (sop_acc) begin
          if (is_legal_len(bus.cfg_pb_len)) begin
            pb_len_d    = bus.cfg_pb_len;
            pb_offset_d = bus.cfg_pb_offset;
            mode_d      = bus.cfg_mode;
            wr_req      = 1'b1;
            wr_base     = bus.cfg_pb_offset;
            wr_idx      = '0;
            idx_d       = ADDR_W'(1);
            state_d     = ST_LOAD;
          end else begin
            err_len_d = 1'b1;
            idx_d     = '0;
            state_d   = ST_IDLE;
          end
        end else if (accept && (state_q == ST_LOAD)) begin
          wr_req = 1'b1;
          if (idx_q == pb_len_q - ADDR_W'(1)) begin
            idx_d   = '0;
            state_d = ST_KICK;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      // The last write is on the bus now; start/din_vld follow it by one cycle.
      ST_KICK: begin
        start_d   = 1'b1;
        din_vld_d = 1'b1;
        run_cnt_d = ADDR_W'(1);
        state_d   = ST_RUN;
      end
      // The KICK cycle counts as the first of the pb_len/4 read cycles.
      ST_RUN: begin
        if (run_cnt_q == (pb_len_q >> 2)) begin
          run_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          din_vld_d = 1'b1;
          run_cnt_d = run_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    s_rdy_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      run_cnt_q   <= '0;
      pb_len_q    <= '0;
      pb_offset_q <= '0;
      mode_q      <= 1'b0;
      s_rdy_q     <= 1'b0;
      start_q     <= 1'b0;
      din_vld_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      run_cnt_q   <= run_cnt_d;
      pb_len_q    <= pb_len_d;
      pb_offset_q <= pb_offset_d;
      mode_q      <= mode_d;
      s_rdy_q     <= s_rdy_d;
      start_q     <= start_d;
      din_vld_q   <= din_vld_d;
      busy_q      <= busy_d;
      err_len_q   <= err_len_d;
    end
  end

  turbo_rx_addr_gen u_addr_gen (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_req  (wr_req),
    .wr_base (wr_base),
    .wr_idx  (wr_idx),
    .wr_data (bus.s_data),
    .wen     (bus.wen),
    .waddr   (bus.waddr),
    .wdata   (bus.wdata)
  );

  assign bus.s_rdy        = s_rdy_q;
  assign bus.pb_offset    = pb_offset_q;
  assign bus.pb_len       = pb_len_q;
  assign bus.mod_int_dint = mode_q;
  assign bus.start        = start_q;
  assign bus.din_vld      = din_vld_q;
  assign bus.busy         = busy_q;
  assign bus.err_len      = err_len_q;

endmodule

// File: tb/tb_turbo_rx_pb_loader.sv
// Self-checking bench for turbo_rx_pb_loader: a table of single-cycle IDLE
// vectors, directed multi-cycle sequences and randomized PBs compared against
// a transaction-level model of expected memory writes and read-phase timing.
module tb_turbo_rx_pb_loader;
  import turbo_rx_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  turbo_rx_pb_loader_if bus();

  turbo_rx_pb_loader dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- output monitor (samples on the falling edge) ----------
  logic [13:0] wq[$];      // observed writes {waddr, wdata}
  logic [13:0] exp_wq[$];  // model's expected writes
  int cyc = 0, last_wen_cyc = 0, start_cnt = 0, start_cyc = 0;
  int dv_cnt = 0, dv_first = 0, dv_last = 0, ovl_cnt = 0;
  int clr_seq = 0, clr_seen = 0;

  always @(negedge clk) begin
    if (clr_seq != clr_seen) begin
      clr_seen  = clr_seq;
      wq.delete();
      start_cnt = 0; start_cyc = 0; last_wen_cyc = 0;
      dv_cnt = 0; dv_first = 0; dv_last = 0; ovl_cnt = 0;
    end
    cyc++;
    if (bus.wen) begin
      wq.push_back({bus.waddr, bus.wdata});
      last_wen_cyc = cyc;
    end
    if (bus.start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (bus.din_vld) begin
      if (dv_cnt == 0) dv_first = cyc;
      dv_cnt++;
      dv_last = cyc;
    end
    if (bus.din_vld && bus.s_rdy) ovl_cnt++;
  end

  // ---------------- driver helpers ----------------------------------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s_vld = 1'b0; bus.s_sop = 1'b0; bus.s_data = '0;
    bus.cfg_pb_len = '0; bus.cfg_pb_offset = '0; bus.cfg_mode = 1'b0;
  endtask

  task automatic clear_obs();
    exp_wq.delete();
    clr_seq++;
    tick();
  endtask

  // Sends pairs 0..n-1 of a PB; each accepted pair adds (offset + i) mod 4096
  // to the expected write list. Config is garbage except on the s_sop pair.
  task automatic send_pb(input logic [11:0] len, input logic [11:0] off, input logic mode,
                         input int n, input int stall_max);
    for (int i = 0; i < n; i++) begin
      logic [1:0] d;
      logic       acc;
      int         tries;
      d = 2'($urandom);
      if (stall_max > 0 && $urandom_range(0, 2) == 0) begin
        bus.s_vld = 1'b0; bus.s_sop = 1'b0;
        repeat ($urandom_range(1, stall_max)) tick();
      end
      bus.s_vld = 1'b1;
      bus.s_sop = (i == 0);
      bus.s_data = d;
      bus.cfg_pb_len    = (i == 0) ? len  : 12'($urandom);
      bus.cfg_pb_offset = (i == 0) ? off  : 12'($urandom);
      bus.cfg_mode      = (i == 0) ? mode : 1'($urandom);
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 64) begin
        acc = bus.s_rdy;
        tick();
        tries++;
      end
      if (!acc) begin
        check("pair_accept_timeout", 32'(i), 32'hFFFF_FFFF);
        i = n;
      end else begin
        exp_wq.push_back({off + 12'(i), d});
      end
    end
    idle_inputs();
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!(dv_cnt > 0 && !bus.busy) && t < 2000) begin
      tick();
      t++;
    end
    check({name, "_done_in_time"}, 32'(t < 2000), 32'd1);
  endtask

  // Compares one completed PB against the model, then clears the observers.
  task automatic check_pb(input string name, input logic [11:0] len, input logic [11:0] off,
                          input logic mode);
    check({name, "_wr_count"}, 32'(wq.size()), 32'(exp_wq.size()));
    for (int i = 0; i < exp_wq.size() && i < wq.size(); i++)
      check({name, "_wr_entry"}, 32'(wq[i]), 32'(exp_wq[i]));
    check({name, "_start_cnt"}, 32'(start_cnt), 32'd1);
    check({name, "_start_after_wen"}, 32'(start_cyc), 32'(last_wen_cyc + 1));
    check({name, "_dv_with_start"}, 32'(dv_first), 32'(start_cyc));
    check({name, "_dv_cycles"}, 32'(dv_cnt), 32'(len / 4));
    check({name, "_dv_contig"}, 32'(dv_last - dv_first + 1), 32'(dv_cnt));
    check({name, "_rdy_in_run"}, 32'(ovl_cnt), 32'd0);
    check({name, "_rdy_after"}, 32'(bus.s_rdy), 32'd1);
    check({name, "_pb_len"}, 32'(bus.pb_len), 32'(len));
    check({name, "_pb_offset"}, 32'(bus.pb_offset), 32'(off));
    check({name, "_mode"}, 32'(bus.mod_int_dint), 32'(mode));
    clear_obs();
  endtask

  // ---------------- IDLE vector table --------------------------------------
  typedef struct {
    logic        vld;
    logic        sop;
    logic [11:0] len;
    logic        exp_err;
    logic        exp_wen;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [11:0] rlen, roff;
    logic        rmode;

    vecs[0] = '{1'b0, 1'b0, 12'h040, 1'b0, 1'b0, 1'b0};  // quiet
    vecs[1] = '{1'b1, 1'b0, 12'h040, 1'b0, 1'b0, 1'b0};  // stray pair dropped
    vecs[2] = '{1'b0, 1'b1, 12'h040, 1'b0, 1'b0, 1'b0};  // sop without valid ignored
    vecs[3] = '{1'b1, 1'b1, 12'h041, 1'b1, 1'b0, 1'b0};  // illegal length
    vecs[4] = '{1'b1, 1'b0, 12'h220, 1'b0, 1'b0, 1'b0};  // stray; err was 1 cycle
    vecs[5] = '{1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 12'h21F, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 12'h040, 1'b0, 1'b0, 1'b0};

    n_rst = 1'b0;
    idle_inputs();
    #2;
    check("rst_s_rdy", 32'(bus.s_rdy), 32'd0);
    check("rst_wen", 32'(bus.wen), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_din_vld", 32'(bus.din_vld), 32'd0);
    check("rst_start", 32'(bus.start), 32'd0);
    check("rst_err_len", 32'(bus.err_len), 32'd0);
    check("rst_pb_len", 32'(bus.pb_len), 32'd0);
    check("rst_waddr", 32'(bus.waddr), 32'd0);
    tick();
    n_rst = 1'b1;
    tick();
    check("post_rst_s_rdy", 32'(bus.s_rdy), 32'd1);

    // Tests 3 and 6: illegal lengths and stray pairs in IDLE.
    for (int i = 0; i < 9; i++) begin
      bus.s_vld = vecs[i].vld;
      bus.s_sop = vecs[i].sop;
      bus.cfg_pb_len = vecs[i].len;
      bus.cfg_pb_offset = 12'h123;
      bus.s_data = 2'($urandom);
      tick();
      check($sformatf("vec%0d_err_len", i), 32'(bus.err_len), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_wen", i), 32'(bus.wen), 32'(vecs[i].exp_wen));
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_s_rdy", i), 32'(bus.s_rdy), 32'd1);
    end
    idle_inputs();
    tick();
    check("vec_end_err_len", 32'(bus.err_len), 32'd0);
    clear_obs();

    // Test 1: PB16 back-to-back at offset 0.
    send_pb(LEN_PB16, 12'h000, 1'b0, 64, 0);
    wait_done("pb16");
    check_pb("pb16", LEN_PB16, 12'h000, 1'b0);

    // Test 2: PB136 at 0xF00 with stalls, wrapping through 0xFFF.
    send_pb(LEN_PB136, 12'hF00, 1'b1, 544, 3);
    wait_done("pb136");
    check("pb136_last_addr", (wq.size() > 0) ? 32'(wq[wq.size()-1][13:2]) : 32'hDEAD,
          32'h11F);
    check_pb("pb136", LEN_PB136, 12'hF00, 1'b1);

    // Test 4: new s_sop at pair 20 of a PB16 aborts it.
    send_pb(LEN_PB16, 12'h100, 1'b0, 20, 0);
    check("abort_no_start", 32'(start_cnt), 32'd0);
    send_pb(LEN_PB16, 12'h300, 1'b1, 64, 0);
    wait_done("abort");
    check_pb("abort", LEN_PB16, 12'h300, 1'b1);

    // Test 5: reset during the read phase.
    send_pb(LEN_PB16, 12'h055, 1'b0, 64, 0);
    begin
      int t = 0;
      while (dv_cnt < 5 && t < 200) begin
        tick();
        t++;
      end
      check("mid_run_reached", 32'(t < 200), 32'd1);
    end
    n_rst = 1'b0;
    #1;
    check("mrst_din_vld", 32'(bus.din_vld), 32'd0);
    check("mrst_start", 32'(bus.start), 32'd0);
    check("mrst_wen", 32'(bus.wen), 32'd0);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    tick();
    n_rst = 1'b1;
    tick();
    check("mrst_s_rdy_after", 32'(bus.s_rdy), 32'd1);
    clear_obs();
    send_pb(LEN_PB16, 12'h7F0, 1'b1, 64, 0);
    wait_done("after_rst");
    check_pb("after_rst", LEN_PB16, 12'h7F0, 1'b1);

    // Randomized PBs: random size, offset, mode and input stalls.
    for (int k = 0; k < 4; k++) begin
      rlen  = ($urandom_range(0, 1) == 1) ? LEN_PB136 : LEN_PB16;
      roff  = 12'($urandom);
      rmode = 1'($urandom);
      send_pb(rlen, roff, rmode, int'(rlen), 2);
      wait_done("rand");
      check_pb("rand", rlen, roff, rmode);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
